// File: rtl/air_hockey_pkg.sv
// Shared table geometry, position bus type and FSM encoding for the air-hockey video path.
package air_hockey_pkg;

    localparam int unsigned POS_W      = 12;
    localparam int unsigned RADIUS_DEF = 20;

    localparam int unsigned TBL_X_MIN = 0;
    localparam int unsigned TBL_X_MID = 512;
    localparam int unsigned TBL_X_MAX = 1023;
    localparam int unsigned TBL_Y_MIN = 0;
    localparam int unsigned TBL_Y_MAX = 767;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLAMP1 = 2'd1,
        ST_CLAMP2 = 2'd2,
        ST_COMMIT = 2'd3
    } state_e;

    typedef struct packed {
        logic [POS_W-1:0] x;
        logic [POS_W-1:0] y;
    } pos_t;

endpackage

// File: rtl/pos_clamp.sv
// Unsigned saturating clamp of one coordinate into [lo, hi].
module pos_clamp
    import air_hockey_pkg::*;
(
    input  logic [POS_W-1:0] value,
    input  logic [POS_W-1:0] lo,
    input  logic [POS_W-1:0] hi,
    output logic [POS_W-1:0] clamped
);

    // Saturate below lo and above hi, pass through otherwise.
    always_comb begin
        clamped = value;
        if (value < lo) begin
            clamped = lo;
        end else if (value > hi) begin
            clamped = hi;
        end
    end

endmodule

// File: rtl/circle_pos_ctrl.sv
// Collects player position requests and commits clamped centres once per frame, at vblank start.
module circle_pos_ctrl
    import air_hockey_pkg::*;
#(
    parameter int unsigned RADIUS = RADIUS_DEF,
    parameter int unsigned X_MIN  = TBL_X_MIN,
    parameter int unsigned X_MID  = TBL_X_MID,
    parameter int unsigned X_MAX  = TBL_X_MAX,
    parameter int unsigned Y_MIN  = TBL_Y_MIN,
    parameter int unsigned Y_MAX  = TBL_Y_MAX,
    parameter int unsigned P1_X0  = 256,
    parameter int unsigned P1_Y0  = 384,
    parameter int unsigned P2_X0  = 768,
    parameter int unsigned P2_Y0  = 384
)(
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             vblnk_in,
    input  logic             p1_valid,
    input  logic             p2_valid,
    output logic             p1_ready,
    output logic             p2_ready,
    input  logic [POS_W-1:0] p1_xpos,
    input  logic [POS_W-1:0] p1_ypos,
    input  logic [POS_W-1:0] p2_xpos,
    input  logic [POS_W-1:0] p2_ypos,
    output logic [POS_W-1:0] xpos_out_player1,
    output logic [POS_W-1:0] ypos_out_player1,
    output logic [POS_W-1:0] xpos_out_player2,
    output logic [POS_W-1:0] ypos_out_player2,
    output logic             update_out,
    output logic             busy
);

    // Each player's x range stays on its own half of the table; y range is shared.
    localparam logic [POS_W-1:0] P1_X_LO = POS_W'(X_MIN + RADIUS);
    localparam logic [POS_W-1:0] P1_X_HI = POS_W'(X_MID - RADIUS);
    localparam logic [POS_W-1:0] P2_X_LO = POS_W'(X_MID + RADIUS);
    localparam logic [POS_W-1:0] P2_X_HI = POS_W'(X_MAX - RADIUS);
    localparam logic [POS_W-1:0] Y_LO    = POS_W'(Y_MIN + RADIUS);
    localparam logic [POS_W-1:0] Y_HI    = POS_W'(Y_MAX - RADIUS);

    state_e state_q, state_d;
    logic   vblnk_q;
    pos_t   pend1_q, pend1_d, pend2_q, pend2_d;
    logic   pend1_vld_q, pend1_vld_d, pend2_vld_q, pend2_vld_d;
    pos_t   stage1_q, stage1_d, stage2_q, stage2_d;
    pos_t   out1_q, out1_d, out2_q, out2_d;
    logic   update_q, update_d;

    logic             frame_start_c;
    logic             acc1_c, acc2_c;
    logic [POS_W-1:0] cx_val_c, cx_lo_c, cx_hi_c, cx_clamped_c;
    logic [POS_W-1:0] cy_val_c, cy_clamped_c;

    assign p1_ready      = (state_q == ST_IDLE);
    assign p2_ready      = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign frame_start_c = vblnk_in && !vblnk_q;
    assign acc1_c        = p1_valid && p1_ready;
    assign acc2_c        = p2_valid && p2_ready;

    // Route the player being clamped this cycle into the shared clamp lanes.
    always_comb begin
        cx_val_c = pend1_q.x;
        cx_lo_c  = P1_X_LO;
        cx_hi_c  = P1_X_HI;
        cy_val_c = pend1_q.y;
        if (state_q == ST_CLAMP2) begin
            cx_val_c = pend2_q.x;
            cx_lo_c  = P2_X_LO;
            cx_hi_c  = P2_X_HI;
            cy_val_c = pend2_q.y;
        end
    end

    pos_clamp u_clamp_x (
        .value   (cx_val_c),
        .lo      (cx_lo_c),
        .hi      (cx_hi_c),
        .clamped (cx_clamped_c)
    );

    pos_clamp u_clamp_y (
        .value   (cy_val_c),
        .lo      (Y_LO),
        .hi      (Y_HI),
        .clamped (cy_clamped_c)
    );

    // Next-state: pending-slot capture, clamp sequencing and the commit of both players.
    always_comb begin
        state_d     = state_q;
        pend1_d     = pend1_q;
        pend2_d     = pend2_q;
        pend1_vld_d = pend1_vld_q;
        pend2_vld_d = pend2_vld_q;
        stage1_d    = stage1_q;
        stage2_d    = stage2_q;
        out1_d      = out1_q;
        out2_d      = out2_q;
        update_d    = 1'b0;

        if (acc1_c) begin
            pend1_d     = '{x: p1_xpos, y: p1_ypos};
            pend1_vld_d = 1'b1;
        end
        if (acc2_c) begin
            pend2_d     = '{x: p2_xpos, y: p2_ypos};
            pend2_vld_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (frame_start_c && (pend1_vld_q || pend2_vld_q || acc1_c || acc2_c)) begin
                    state_d = ST_CLAMP1;
                end
            end
            ST_CLAMP1: begin
                stage1_d = '{x: cx_clamped_c, y: cy_clamped_c};
                state_d  = ST_CLAMP2;
            end
            ST_CLAMP2: begin
                stage2_d = '{x: cx_clamped_c, y: cy_clamped_c};
                state_d  = ST_COMMIT;
            end
            ST_COMMIT: begin
                if (pend1_vld_q) out1_d = stage1_q;
                if (pend2_vld_q) out2_d = stage2_q;
                pend1_vld_d = 1'b0;
                pend2_vld_d = 1'b0;
                update_d    = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset discards anything pending or staged.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            vblnk_q     <= 1'b0;
            pend1_q     <= '0;
            pend2_q     <= '0;
            pend1_vld_q <= 1'b0;
            pend2_vld_q <= 1'b0;
            stage1_q    <= '0;
            stage2_q    <= '0;
            out1_q      <= '{x: POS_W'(P1_X0), y: POS_W'(P1_Y0)};
            out2_q      <= '{x: POS_W'(P2_X0), y: POS_W'(P2_Y0)};
            update_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            vblnk_q     <= vblnk_in;
            pend1_q     <= pend1_d;
            pend2_q     <= pend2_d;
            pend1_vld_q <= pend1_vld_d;
            pend2_vld_q <= pend2_vld_d;
            stage1_q    <= stage1_d;
            stage2_q    <= stage2_d;
            out1_q      <= out1_d;
            out2_q      <= out2_d;
            update_q    <= update_d;
        end
    end

    assign xpos_out_player1 = out1_q.x;
    assign ypos_out_player1 = out1_q.y;
    assign xpos_out_player2 = out2_q.x;
    assign ypos_out_player2 = out2_q.y;
    assign update_out       = update_q;

endmodule

// File: tb/tb_circle_pos_ctrl.sv
// Bench for circle_pos_ctrl: directed and random frames against a per-frame commit model.
`timescale 1ns/1ps
module tb_circle_pos_ctrl;

    localparam int RAD  = 20;
    localparam int XMIN = 0;
    localparam int XMID = 512;
    localparam int XMAX = 1023;
    localparam int YMIN = 0;
    localparam int YMAX = 767;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic        vblnk_in = 1'b0;
    logic        p1_valid = 1'b0, p2_valid = 1'b0;
    logic        p1_ready, p2_ready;
    logic [11:0] p1_xpos = '0, p1_ypos = '0, p2_xpos = '0, p2_ypos = '0;
    logic [11:0] xpos_out_player1, ypos_out_player1, xpos_out_player2, ypos_out_player2;
    logic        update_out, busy;

    always #5 clk_in = ~clk_in;

    circle_pos_ctrl dut (
        .clk_in           (clk_in),
        .rst_n            (rst_n),
        .vblnk_in         (vblnk_in),
        .p1_valid         (p1_valid),
        .p2_valid         (p2_valid),
        .p1_ready         (p1_ready),
        .p2_ready         (p2_ready),
        .p1_xpos          (p1_xpos),
        .p1_ypos          (p1_ypos),
        .p2_xpos          (p2_xpos),
        .p2_ypos          (p2_ypos),
        .xpos_out_player1 (xpos_out_player1),
        .ypos_out_player1 (ypos_out_player1),
        .xpos_out_player2 (xpos_out_player2),
        .ypos_out_player2 (ypos_out_player2),
        .update_out       (update_out),
        .busy             (busy)
    );

    wire [47:0] out_bus = {xpos_out_player1, ypos_out_player1, xpos_out_player2, ypos_out_player2};

    // Reference model: what is on screen, and what each player has asked for since last commit.
    int exp_x[2], exp_y[2], req_x[2], req_y[2];
    bit pend[2];
    int total = 0;
    int bad   = 0;

    function automatic int clampv(int v, int lo, int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic int x_lo(int p);
        return (p == 0) ? XMIN + RAD : XMID + RAD;
    endfunction

    function automatic int x_hi(int p);
        return (p == 0) ? XMID - RAD : XMAX - RAD;
    endfunction

    function automatic logic [47:0] exp_bus();
        return {12'(exp_x[0]), 12'(exp_y[0]), 12'(exp_x[1]), 12'(exp_y[1])};
    endfunction

    function automatic void model_reset();
        exp_x[0] = 256; exp_y[0] = 384;
        exp_x[1] = 768; exp_y[1] = 384;
        pend[0] = 1'b0; pend[1] = 1'b0;
    endfunction

    task automatic drive_valid(input int p, input logic v, input int x, input int y);
        if (p == 0) begin
            p1_valid = v; p1_xpos = 12'(x); p1_ypos = 12'(y);
        end else begin
            p2_valid = v; p2_xpos = 12'(x); p2_ypos = 12'(y);
        end
    endtask

    // One-cycle offer while idle; the slot is overwritten by later offers.
    task automatic offer(input int p, input int x, input int y, input string tag);
        drive_valid(p, 1'b1, x, y);
        total++;
        if (((p == 0) ? p1_ready : p2_ready) !== 1'b1) begin
            bad++; $display("FAIL %s ready: got %b want 1", tag, (p == 0) ? p1_ready : p2_ready);
        end
        req_x[p] = x; req_y[p] = y; pend[p] = 1'b1;
        @(negedge clk_in);
        drive_valid(p, 1'b0, 0, 0);
    endtask

    // Raise vblank (optionally with a same-cycle offer) and check the whole commit sequence.
    task automatic run_frame(input bit extra, input int ep, input int ex, input int ey, input string tag);
        int nx[2], ny[2];
        bit any;
        logic [47:0] old_bus;
        vblnk_in = 1'b1;
        if (extra) begin
            drive_valid(ep, 1'b1, ex, ey);
            req_x[ep] = ex; req_y[ep] = ey; pend[ep] = 1'b1;
        end
        any = pend[0] | pend[1];
        for (int p = 0; p < 2; p++) begin
            nx[p] = pend[p] ? clampv(req_x[p], x_lo(p), x_hi(p)) : exp_x[p];
            ny[p] = pend[p] ? clampv(req_y[p], YMIN + RAD, YMAX - RAD) : exp_y[p];
        end
        old_bus = exp_bus();
        @(negedge clk_in);
        if (extra) drive_valid(ep, 1'b0, 0, 0);
        if (!any) begin
            for (int k = 0; k < 4; k++) begin
                total++;
                if (busy !== 1'b0 || update_out !== 1'b0 || out_bus !== old_bus) begin
                    bad++; $display("FAIL %s idle_frame c%0d: busy=%b upd=%b out=%h want busy=0 upd=0 out=%h",
                                    tag, k, busy, update_out, out_bus, old_bus);
                end
                @(negedge clk_in);
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                total++;
                if (busy !== 1'b1 || p1_ready !== 1'b0 || p2_ready !== 1'b0 ||
                    update_out !== 1'b0 || out_bus !== old_bus) begin
                    bad++; $display("FAIL %s busy c%0d: busy=%b rdy=%b%b upd=%b out=%h want 1 00 0 %h",
                                    tag, k, busy, p1_ready, p2_ready, update_out, out_bus, old_bus);
                end
                @(negedge clk_in);
            end
            for (int p = 0; p < 2; p++) begin
                exp_x[p] = nx[p]; exp_y[p] = ny[p]; pend[p] = 1'b0;
            end
            total++;
            if (update_out !== 1'b1 || out_bus !== exp_bus() || busy !== 1'b0 || p1_ready !== 1'b1) begin
                bad++; $display("FAIL %s commit: upd=%b out=%h busy=%b rdy=%b want upd=1 out=%h busy=0 rdy=1",
                                tag, update_out, out_bus, busy, p1_ready, exp_bus());
            end
            @(negedge clk_in);
            total++;
            if (update_out !== 1'b0) begin
                bad++; $display("FAIL %s pulse_len: upd=%b want 0", tag, update_out);
            end
        end
        vblnk_in = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        model_reset();
        @(negedge clk_in);
        total++;
        if (out_bus !== exp_bus() || update_out !== 1'b0 || busy !== 1'b0 || p1_ready !== 1'b1 || p2_ready !== 1'b1) begin
            bad++; $display("FAIL reset_hold: out=%h upd=%b busy=%b rdy=%b%b want out=%h 0 0 11",
                            out_bus, update_out, busy, p1_ready, p2_ready, exp_bus());
        end
        rst_n = 1'b1;
        @(negedge clk_in);
        total++;
        if (out_bus !== {12'd256, 12'd384, 12'd768, 12'd384} || update_out !== 1'b0 || p1_ready !== 1'b1) begin
            bad++; $display("FAIL reset_release: out=%h upd=%b rdy=%b want 100180300180 0 1",
                            out_bus, update_out, p1_ready);
        end
    endtask

    task automatic test_clamp_hi();
        offer(0, 600, 300, "p1_600_300");
        run_frame(1'b0, 0, 0, 0, "p1_600_300");
        total++;
        if (out_bus !== {12'd492, 12'd300, 12'd768, 12'd384}) begin
            bad++; $display("FAIL p1_600_300 const: got %h want %h", out_bus, {12'd492, 12'd300, 12'd768, 12'd384});
        end
    endtask

    task automatic test_latest_wins();
        offer(1, 1020, 5, "p2_latest_a");
        @(negedge clk_in);
        offer(1, 800, 400, "p2_latest_b");
        run_frame(1'b0, 0, 0, 0, "p2_latest");
        total++;
        if (xpos_out_player2 !== 12'd800 || ypos_out_player2 !== 12'd400) begin
            bad++; $display("FAIL p2_latest const: got (%0d,%0d) want (800,400)", xpos_out_player2, ypos_out_player2);
        end
    endtask

    task automatic test_clamp_edges();
        offer(1, 1020, 5, "p2_corner");
        run_frame(1'b0, 0, 0, 0, "p2_corner");
        total++;
        if (xpos_out_player2 !== 12'd1003 || ypos_out_player2 !== 12'd20) begin
            bad++; $display("FAIL p2_corner const: got (%0d,%0d) want (1003,20)", xpos_out_player2, ypos_out_player2);
        end
        offer(0, 10, 760, "p1_corner");
        run_frame(1'b0, 0, 0, 0, "p1_corner");
        total++;
        if (xpos_out_player1 !== 12'd20 || ypos_out_player1 !== 12'd747) begin
            bad++; $display("FAIL p1_corner const: got (%0d,%0d) want (20,747)", xpos_out_player1, ypos_out_player1);
        end
    endtask

    task automatic test_same_cycle();
        run_frame(1'b1, 0, 300, 300, "same_cycle");
        total++;
        if (xpos_out_player1 !== 12'd300 || ypos_out_player1 !== 12'd300) begin
            bad++; $display("FAIL same_cycle const: got (%0d,%0d) want (300,300)", xpos_out_player1, ypos_out_player1);
        end
    endtask

    task automatic test_no_pending();
        run_frame(1'b0, 0, 0, 0, "no_pending");
    endtask

    // Second vblank rise lands in CLAMP2 and an offer is made while busy: both must be ignored.
    task automatic test_busy_ignore();
        offer(1, 700, 700, "busy_ign");
        vblnk_in = 1'b1;
        @(negedge clk_in);
        vblnk_in = 1'b0;
        drive_valid(0, 1'b1, 50, 50);
        @(negedge clk_in);
        vblnk_in = 1'b1;
        @(negedge clk_in);
        drive_valid(0, 1'b0, 0, 0);
        @(negedge clk_in);
        exp_x[1] = 700; exp_y[1] = 700; pend[1] = 1'b0;
        total++;
        if (update_out !== 1'b1 || out_bus !== exp_bus()) begin
            bad++; $display("FAIL busy_ign commit: upd=%b out=%h want 1 %h", update_out, out_bus, exp_bus());
        end
        vblnk_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_in);
            total++;
            if (busy !== 1'b0 || update_out !== 1'b0) begin
                bad++; $display("FAIL busy_ign after c%0d: busy=%b upd=%b want 0 0", k, busy, update_out);
            end
        end
        run_frame(1'b0, 0, 0, 0, "busy_ign_followup");
    endtask

    task automatic test_reset_mid();
        offer(0, 100, 100, "rst_mid");
        offer(1, 900, 600, "rst_mid");
        vblnk_in = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        rst_n = 1'b0;
        vblnk_in = 1'b0;
        model_reset();
        #1;
        total++;
        if (out_bus !== exp_bus() || busy !== 1'b0 || p1_ready !== 1'b1 || update_out !== 1'b0) begin
            bad++; $display("FAIL rst_mid assert: out=%h busy=%b rdy=%b upd=%b want %h 0 1 0",
                            out_bus, busy, p1_ready, update_out, exp_bus());
        end
        @(negedge clk_in);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_in);
            total++;
            if (update_out !== 1'b0 || out_bus !== exp_bus()) begin
                bad++; $display("FAIL rst_mid after c%0d: upd=%b out=%h want 0 %h", k, update_out, out_bus, exp_bus());
            end
        end
        run_frame(1'b0, 0, 0, 0, "rst_mid_followup");
    endtask

    task automatic test_random();
        for (int it = 0; it < 16; it++) begin
            for (int p = 0; p < 2; p++) begin
                int n;
                n = int'($urandom_range(0, 2));
                for (int j = 0; j < n; j++) begin
                    offer(p, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)), "rand_offer");
                end
            end
            if ($urandom_range(0, 2) == 0) begin
                run_frame(1'b1, int'($urandom_range(0, 1)), int'($urandom_range(0, 4095)),
                          int'($urandom_range(0, 4095)), "rand_frame_sc");
            end else begin
                run_frame(1'b0, 0, 0, 0, "rand_frame");
            end
        end
    endtask

    initial begin
        test_reset();
        test_clamp_hi();
        test_latest_wins();
        test_clamp_edges();
        test_same_cycle();
        test_no_pending();
        test_busy_ignore();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
